// File: rtl/digit_overlay_gen_pkg.sv
// Shared constants and types for the digit overlay generator.
// Cell geometry, segment bounds, blank code and 7-segment table.
package digit_overlay_gen_pkg;

  localparam int CELL_W = 16;
  localparam int CELL_H = 24;

  localparam logic [3:0] BLANK = 4'hF;

  // Segment masks: bit0=a .. bit6=g.
  // Codes 10..15 are blank.
  localparam logic [15:0][6:0] SEG_TABLE = {
    {6{7'h00}},
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Inclusive segment rectangles in cell-local coords.
  // Packed order is {g,f,e,d,c,b,a}.
  localparam logic [6:0][3:0] SEG_X_LO =
    {4'd2, 4'd2, 4'd2, 4'd2, 4'd11, 4'd11, 4'd2};
  localparam logic [6:0][3:0] SEG_X_HI =
    {4'd13, 4'd4, 4'd4, 4'd13, 4'd13, 4'd13, 4'd13};
  localparam logic [6:0][4:0] SEG_Y_LO =
    {5'd11, 5'd1, 5'd12, 5'd20, 5'd12, 5'd1, 5'd1};
  localparam logic [6:0][4:0] SEG_Y_HI =
    {5'd13, 5'd11, 5'd22, 5'd22, 5'd22, 5'd11, 5'd3};

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] data;
  } vid_t;

  typedef struct packed {
    vid_t       vid;
    logic       hit;
    logic [2:0] idx;
    logic [3:0] lx;
    logic [4:0] ly;
  } s1_t;

  // Which segment rectangles contain (lx, ly).
  function automatic logic [6:0] seg_region(
    logic [3:0] lx,
    logic [4:0] ly
  );
    logic [6:0] r;
    for (int i = 0; i < 7; i++) begin
      r[i] = (lx >= SEG_X_LO[i]) && (lx <= SEG_X_HI[i]) &&
             (ly >= SEG_Y_LO[i]) && (ly <= SEG_Y_HI[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_overlay_gen_seg.sv
// digit_seg_decode: 4-bit digit to 7-bit segment mask (bit0=a).
// Ports: digit in, seg out; purely combinational.
module digit_seg_decode
  import digit_overlay_gen_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/digit_overlay_gen.sv
// Seven-segment digit overlay on a pixel stream, 2-cycle latency.
// Ports: video in/out, back-buffer write, overlay origin and enable.
module digit_overlay_gen
  import digit_overlay_gen_pkg::*;
#(
  parameter int          NUM_CHARS = 8,
  parameter logic [23:0] FG_COLOR  = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [23:0] i_data,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [3:0]  wr_digit,
  input  logic [11:0] org_x,
  input  logic [11:0] org_y,
  input  logic        ovl_en,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic [23:0] o_data
);

  localparam logic [3:0]  NC     = 4'(NUM_CHARS);
  localparam logic [12:0] SPAN_X = 13'(NUM_CHARS * CELL_W);
  localparam logic [12:0] SPAN_Y = 13'(CELL_H);

  logic [7:0][3:0] back_q, back_d;
  logic [7:0][3:0] front_q, front_d;
  logic [11:0]     ox_q, ox_d, oy_q, oy_d;
  logic            en_q, en_d, vs_q, vs_d;
  s1_t             s1_q, s1_d;
  vid_t            s2_q, s2_d;

  logic        swap, in_x, in_y, lit;
  logic [12:0] x13, y13, ox13, oy13, dx, dy;
  logic [3:0]  cur_digit;
  logic [6:0]  seg;

  // Buffers and latched overlay controls.
  // front takes the pre-write back value on a swap.
  always_comb begin
    swap    = vs_q & ~i_vs;
    vs_d    = i_vs;
    back_d  = back_q;
    front_d = front_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    en_d    = en_q;
    if (swap) begin
      front_d = back_q;
      ox_d    = org_x;
      oy_d    = org_y;
      en_d    = ovl_en;
    end
    if (wr_en && ({1'b0, wr_addr} < NC)) begin
      back_d[wr_addr] = wr_digit;
    end
  end

  // Stage 1: cell hit. 13-bit math so cells
  // past 4095 clip instead of wrapping to x=0.
  always_comb begin
    x13  = {1'b0, i_x};
    y13  = {1'b0, i_y};
    ox13 = {1'b0, ox_q};
    oy13 = {1'b0, oy_q};
    dx   = x13 - ox13;
    dy   = y13 - oy13;
    in_x = (x13 >= ox13) && (dx < SPAN_X);
    in_y = (y13 >= oy13) && (dy < SPAN_Y);
    s1_d     = '0;
    s1_d.vid = {i_hs, i_vs, i_de, i_x, i_y, i_data};
    s1_d.hit = en_q & in_x & in_y;
    s1_d.idx = dx[6:4];
    s1_d.lx  = dx[3:0];
    s1_d.ly  = dy[4:0];
  end

  // Stage 2: segment lookup and colour mux.
  always_comb begin
    cur_digit = front_q[s1_q.idx];
  end

  digit_seg_decode u_dec (
    .digit (cur_digit),
    .seg   (seg)
  );

  always_comb begin
    lit  = s1_q.hit & |(seg & seg_region(s1_q.lx, s1_q.ly));
    s2_d = s1_q.vid;
    if (lit && s1_q.vid.de) begin
      s2_d.data = FG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      back_q  <= {8{BLANK}};
      front_q <= {8{BLANK}};
      ox_q    <= '0;
      oy_q    <= '0;
      en_q    <= 1'b0;
      vs_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      back_q  <= back_d;
      front_q <= front_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      en_q    <= en_d;
      vs_q    <= vs_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  assign o_hs   = s2_q.hs;
  assign o_vs   = s2_q.vs;
  assign o_de   = s2_q.de;
  assign o_x    = s2_q.x;
  assign o_y    = s2_q.y;
  assign o_data = s2_q.data;

endmodule

// File: tb/tb_digit_overlay_gen.sv
// Testbench for digit_overlay_gen: random pixels vs a
// rectangle/segment-string reference model, plus directed probes.
module tb_digit_overlay_gen;

  localparam int          NC = 8;
  localparam logic [23:0] FG = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_hs, i_vs, i_de;
  logic [11:0] i_x, i_y;
  logic [23:0] i_data;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_digit;
  logic [11:0] org_x, org_y;
  logic        ovl_en;
  logic        o_hs, o_vs, o_de;
  logic [11:0] o_x, o_y;
  logic [23:0] o_data;

  always #5 clk = ~clk;

  digit_overlay_gen #(.NUM_CHARS(NC), .FG_COLOR(FG)) dut (
    .clk(clk), .rst(rst),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_x(i_x), .i_y(i_y), .i_data(i_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_digit(wr_digit),
    .org_x(org_x), .org_y(org_y), .ovl_en(ovl_en),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
    .o_x(o_x), .o_y(o_y), .o_data(o_data)
  );

  int n_err = 0;
  int n_chk = 0;
  int fg_cnt = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_back [8];
  int m_front [8];
  int m_ox, m_oy;
  bit m_en, m_vs;

  string segs [10] = '{"abcdef", "bc", "abdeg", "abcdg",
    "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
  int rx0 [7] = '{2, 11, 11, 2, 2, 2, 2};
  int rx1 [7] = '{13, 13, 13, 13, 4, 4, 13};
  int ry0 [7] = '{1, 1, 12, 20, 12, 1, 11};
  int ry1 [7] = '{3, 11, 22, 22, 22, 11, 13};

  function automatic bit seg_on(int d, int lx, int ly);
    string s;
    int k;
    if (d > 9) return 1'b0;
    s = segs[d];
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 97;
      if (lx >= rx0[k] && lx <= rx1[k] &&
          ly >= ry0[k] && ly <= ry1[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_back[i]  = 15;
      m_front[i] = 15;
    end
    m_ox = 0; m_oy = 0; m_en = 0; m_vs = 0;
  endtask

  function automatic logic [50:0] model_out();
    int dx, dy;
    bit lit;
    lit = 1'b0;
    dx = int'(i_x) - m_ox;
    dy = int'(i_y) - m_oy;
    if (m_en && i_de && dx >= 0 && dx < NC * 16 &&
        dy >= 0 && dy < 24)
      lit = seg_on(m_front[dx / 16], dx % 16, dy);
    return {i_hs, i_vs, i_de, i_x, i_y, lit ? FG : i_data};
  endfunction

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      if (m_vs && !i_vs) begin
        m_front = m_back;
        m_ox = int'(org_x);
        m_oy = int'(org_y);
        m_en = ovl_en;
      end
      if (wr_en && int'(wr_addr) < NC)
        m_back[wr_addr] = int'(wr_digit);
      m_vs = i_vs;
    end
  endtask

  logic [50:0] pend = '0;
  bit          pend_probe = 0;
  bit          pend_lit = 0;
  string       pend_tag = "";

  // One clock: inputs already driven; outputs checked
  // against the pixel driven one tick earlier.
  task automatic tick(input bit probe = 0,
                      input bit plit = 0,
                      input string ptag = "");
    logic [50:0] e;
    e = rst ? '0 : model_out();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (rst) begin
      pend = '0;
      pend_probe = 0;
    end
    check("pix", {o_hs, o_vs, o_de, o_x, o_y, o_data}, pend);
    if (pend_probe) check(pend_tag, o_data == FG, pend_lit);
    if (o_data == FG) fg_cnt++;
    pend = e;
    pend_probe = probe && !rst;
    pend_lit = plit;
    pend_tag = ptag;
  endtask

  task automatic px(input int x, input int y, input bit de,
                    input logic [23:0] d,
                    input bit probe = 0, input bit plit = 0,
                    input string ptag = "");
    i_x = 12'(x);
    i_y = 12'(y);
    i_de = de;
    i_data = d;
    i_hs = 1'($urandom);
    i_vs = 1'b1;
    tick(probe, plit, ptag);
  endtask

  task automatic wr(input int a, input int dg);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_digit = 4'(dg);
    px(0, 0, 0, 24'h0);
    wr_en = 1'b0;
  endtask

  // vs low for a few cycles; optional write on the swap cycle.
  task automatic vs_gap(input bit w = 0, input int a = 0,
                        input int dg = 0);
    for (int i = 0; i < 3; i++) begin
      i_vs = 1'b0;
      i_de = 1'b0;
      i_hs = 1'b0;
      i_x = 12'($urandom);
      i_y = 12'($urandom);
      i_data = 24'($urandom);
      wr_en = w && (i == 0);
      wr_addr = 3'(a);
      wr_digit = 4'(dg);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic rand_frame(input int n, input int ox, input int oy,
                            input bit w = 0);
    for (int i = 0; i < n; i++) begin
      wr_en = w && ($urandom_range(15, 0) == 0);
      wr_addr = 3'($urandom);
      wr_digit = 4'($urandom);
      px(ox - 4 + int'($urandom_range(136, 0)),
         oy - 3 + int'($urandom_range(30, 0)),
         $urandom_range(3, 0) != 0,
         24'($urandom) & 24'h7FFFFF);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_hs = 0; i_vs = 0; i_de = 0;
    i_x = 0; i_y = 0; i_data = 0;
    wr_en = 0; wr_addr = 0; wr_digit = 0;
    org_x = 0; org_y = 0; ovl_en = 0;
    model_reset();
    repeat (3) tick();
    check("reset_out", {o_hs, o_vs, o_de, o_x, o_y, o_data}, 0);
    rst = 1'b0;

    // Frame A: overlay enabled at input but not yet latched
    org_x = 100; org_y = 50; ovl_en = 1'b1;
    fg_cnt = 0;
    wr(0, 8);
    rand_frame(200, 100, 50);
    px(102, 51, 1, 24'h55, 1, 0, "pre_swap");
    px(0, 0, 0, 24'h0);
    px(0, 0, 0, 24'h0);
    check("no_fg_first_frame", fg_cnt, 0);

    // Frame B: digit 8 in cell 0
    vs_gap();
    px(102, 51, 1, 24'h55, 1, 1, "seg_a_lo");
    px(113, 53, 1, 24'h55, 1, 1, "seg_a_hi");
    px(104, 62, 1, 24'h55, 1, 1, "seg_e_top");
    px(102, 57, 1, 24'h55, 1, 1, "seg_f");
    px(100, 50, 1, 24'h55, 1, 0, "origin_pass");
    px(108, 60, 1, 24'h55, 1, 0, "cell0_hole");
    px(102, 51, 0, 24'h55, 1, 0, "lit_de0");
    wr(1, 1);
    rand_frame(300, 100, 50);
    px(127, 51, 1, 24'h55, 1, 0, "cell1_not_yet");

    // Swap with a write on the swap cycle itself
    vs_gap(1, 2, 5);
    px(127, 51, 1, 24'h55, 1, 1, "cell1_b");
    px(129, 72, 1, 24'h55, 1, 1, "cell1_c");
    px(120, 52, 1, 24'h55, 1, 0, "cell1_off");
    px(134, 51, 1, 24'h55, 1, 0, "cell2_old");
    rand_frame(300, 100, 50);

    vs_gap();
    px(134, 51, 1, 24'h55, 1, 1, "cell2_new");
    rand_frame(200, 100, 50);

    // Right edge: origin 4090, all cells = 8
    org_x = 4090;
    for (int k = 0; k < NC; k++) wr(k, 8);
    vs_gap();
    px(4092, 51, 1, 24'h55, 1, 1, "edge_lit");
    px(2, 51, 1, 24'h55, 1, 0, "no_wrap_x2");
    px(11, 60, 1, 24'h55, 1, 0, "no_wrap_x11");
    rand_frame(300, 4090, 50);

    // Reset mid-frame with overlay active
    px(4092, 51, 1, 24'h55);
    rst = 1'b1;
    px(4092, 51, 1, 24'h55);
    check("rst_midframe_out",
          {o_hs, o_vs, o_de, o_x, o_y, o_data}, 0);
    px(4092, 51, 1, 24'h55);
    rst = 1'b0;
    px(4092, 51, 1, 24'h55, 1, 0, "post_rst_pass");
    org_x = 100;
    wr(0, 8);
    rand_frame(200, 4090, 50);
    px(102, 51, 1, 24'h55, 1, 0, "post_rst_still_pass");
    vs_gap();
    px(102, 51, 1, 24'h55, 1, 1, "post_rst_relit");

    // Random frames: random origin, enable and writes
    for (int f = 0; f < 8; f++) begin
      int ox, oy;
      ox = int'($urandom_range(4095, 0));
      oy = int'($urandom_range(4095, 0));
      if (f < 3) ox = 4095 - int'($urandom_range(140, 0));
      org_x = 12'(ox);
      org_y = 12'(oy);
      ovl_en = ($urandom_range(3, 0) != 0);
      for (int k = 0; k < NC; k++) wr(k, int'($urandom_range(15, 0)));
      vs_gap($urandom_range(1, 0) == 1, int'($urandom_range(7, 0)),
             int'($urandom_range(15, 0)));
      rand_frame(600, ox, oy, 1);
    end

    px(0, 0, 0, 24'h0);
    px(0, 0, 0, 24'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/digit_overlay_gen.md
DIGIT_OVERLAY_GEN -- requirements
Module: digit_overlay_gen

Interface
REQ-001 Parameter NUM_CHARS, default 8: number of character cells, range 1..8.
REQ-002 Parameter FG_COLOR, default 24'hFF0000: RGB888 colour of lit segment pixels.
REQ-003 Port clk, input, 1: single pixel clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Ports i_hs, i_vs, i_de, input, 1 each: video timing; i_vs is high during the active frame.
REQ-006 Ports i_x and i_y, input, 12 each: current pixel position.
REQ-007 Port i_data, input, 24: RGB888 pixel.
REQ-008 Ports wr_en (1), wr_addr (3) and wr_digit (4), input: back-buffer write port.
REQ-009 Ports org_x and org_y, input, 12 each: top-left corner of the overlay.
REQ-010 Port ovl_en, input, 1: overlay enable.
REQ-011 Ports o_hs, o_vs, o_de (1 each), o_x and o_y (12 each), o_data (24), output: delayed video with overlay applied.

Function
REQ-012 Write: on wr_en=1 with wr_addr<NUM_CHARS, back[wr_addr] SHALL take wr_digit next cycle; wr_addr>=NUM_CHARS is ignored.
REQ-013 Swap: on an i_vs 1->0 transition (registered i_vs=1, i_vs=0), front[] SHALL copy back[] and org_x, org_y and ovl_en SHALL be latched, all in one cycle.
REQ-014 Write on the swap cycle: the back buffer SHALL be updated; front SHALL receive the pre-write back value. The write becomes visible at the next swap.
REQ-015 Cell geometry: 16x24 pixels; cell k spans x in [org_x+16k, org_x+16k+15] and y in [org_y, org_y+23].
REQ-016 Coordinate arithmetic SHALL use 13 bits without wrap-around; cells extending beyond 4095 are clipped.
REQ-017 Segments use local coordinates (lx, ly) inside the cell; all ranges are inclusive:
  a: ly 1-3, lx 2-13
  b: lx 11-13, ly 1-11
  c: lx 11-13, ly 12-22
  d: ly 20-22, lx 2-13
  e: lx 2-4, ly 12-22
  f: lx 2-4, ly 1-11
  g: ly 11-13, lx 2-13
REQ-018 Segment map: standard 7-segment patterns for digits 0-9; values 10-15 render blank.
REQ-019 A pixel is lit when latched ovl_en=1, it is inside a cell, and it hits a segment enabled for front[k].
REQ-020 o_data SHALL be FG_COLOR when lit and the delayed de=1; otherwise it SHALL be the delayed i_data.
REQ-021 Pipeline: exactly 2 cycles of latency on every output.
  Stage 1 registers: cell hit, cell index, lx, ly, plus the video signals.
  Stage 2 registers: the colour mux result.
REQ-022 hs, vs, de, x and y SHALL be delayed identically to data, so their alignment is preserved.
REQ-023 The block never stalls and has no backpressure; one pixel is accepted per clock.

Reset
REQ-024 While rst=1, all outputs SHALL be 0.
REQ-025 While rst=1, back[] and front[] SHALL be 4'hF (blank) and latched ovl_en SHALL be 0.
REQ-026 While rst=1, latched origin SHALL be 0 and the vs edge register SHALL be 0.
REQ-027 Reset mid-frame: no overlay SHALL appear until the first swap after reset is released.

Structure
REQ-028 A shared package SHALL hold the cell size constants (16, 24), the segment bounds, the BLANK code 4'hF and the 7-segment table.
REQ-029 One sub-module, digit_seg_decode, SHALL be used: combinational 4-bit digit -> 7-bit segment mask (a..g).

Verification
REQ-030 Reset, then one frame of video with ovl_en=1 -> o_data equals i_data delayed 2 cycles; no FG pixels.
REQ-031 Write back[0]=8, org=(100,50), ovl_en=1, vs falls -> next frame, pixels (102..113, 51..53) and (102..104, 51..62) = FG_COLOR, and (100,50) = passthrough.
REQ-032 Write back[1]=1 during frame N -> frame N unchanged; in frame N+1, only segments b and c of cell 1 are lit (x 127..129, y 51..72).
REQ-033 Write on the exact swap cycle -> front gets the old value; the new digit appears one frame later.
REQ-034 org_x=4090 with 8 cells -> no wrap; x 0..15 never lit; timing outputs stay aligned.
REQ-035 Assert rst mid-frame with overlay active -> outputs 0 the next cycle; after release, passthrough only until the next vs fall.
